// File: rtl/decode_ctrl_seq.sv
// Decode-stage opcode/modrm control: one instruction in, registered uop(s) out; 1-cycle latency.
// Output register stalls while out_valid & !out_ready; XCHG may expand into two uops via the sequencer.
module decode_ctrl_seq #(
    parameter int REG_W       = 5,
    parameter int ALU_W       = 4,
    parameter int EXPAND_XCHG = 1,
    parameter int UOP_IDX_W   = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_sizeov,
    input  logic [15:0]          in_opcode,
    input  logic [7:0]           in_modrm,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_setd,
    output logic                 out_cleard,
    output logic [2:0]           out_size,
    output logic [2:0]           out_op0_type,
    output logic [2:0]           out_op1_type,
    output logic [REG_W-1:0]     out_op0_reg,
    output logic [REG_W-1:0]     out_op1_reg,
    output logic [ALU_W-1:0]     out_alu_op,
    output logic                 out_flag_wr,
    output logic [1:0]           out_stack_op,
    output logic [UOP_IDX_W-1:0] out_uop_idx,
    output logic                 out_uop_last,
    output logic                 out_illegal
);

    localparam logic [2:0] T_NONE = 3'd0;
    localparam logic [2:0] T_REG  = 3'd1;
    localparam logic [2:0] T_MEM  = 3'd2;
    localparam logic [2:0] T_IMM  = 3'd3;
    localparam logic [2:0] T_STK  = 3'd4;

    localparam logic [ALU_W-1:0] ALU_MOV  = ALU_W'(8);
    localparam logic [ALU_W-1:0] ALU_XCHG = ALU_W'(9);
    localparam logic [ALU_W-1:0] ALU_NOP  = ALU_W'(15);

    typedef struct packed {
        logic                 setd;
        logic                 cleard;
        logic [2:0]           size;
        logic [2:0]           op0_type;
        logic [2:0]           op1_type;
        logic [REG_W-1:0]     op0_reg;
        logic [REG_W-1:0]     op1_reg;
        logic [ALU_W-1:0]     alu_op;
        logic                 flag_wr;
        logic [1:0]           stack_op;
        logic [UOP_IDX_W-1:0] uop_idx;
        logic                 uop_last;
        logic                 illegal;
    } uop_t;

    typedef enum logic {S_IDLE, S_EXP1} state_t;

    state_t r_state, w_state_nxt;
    uop_t   r_uop, r_uop1, w_dec, w_dec_u1;
    logic   r_out_vld, w_valid_nxt;
    logic   w_in_rdy, w_ld_dec, w_ld_u1, w_is_xchg;

    logic [7:0]       w_p;
    logic             w_w, w_d;
    logic [2:0]       w_size, w_stk_size;
    logic [1:0]       w_cls, w_stk_cls;
    logic [REG_W-1:0] w_reg_sel, w_rm_sel, w_acc_sel, w_op_reg_sel;
    logic [2:0]       w_rm_type;
    logic             w_unused;

    // The second opcode byte only matters behind 0x0F, which is decoded as illegal.
    assign w_unused = ^in_opcode[15:8];

    assign w_p          = in_opcode[7:0];
    assign w_w          = w_p[0];
    assign w_d          = w_p[1];
    assign w_size       = !w_w ? 3'b001 : (in_sizeov ? 3'b010 : 3'b100);
    assign w_cls        = !w_w ? 2'b00  : (in_sizeov ? 2'b01  : 2'b10);
    assign w_stk_size   = in_sizeov ? 3'b010 : 3'b100;
    assign w_stk_cls    = in_sizeov ? 2'b01  : 2'b10;
    assign w_reg_sel    = REG_W'({w_cls, in_modrm[5:3]});
    assign w_rm_sel     = REG_W'({w_cls, in_modrm[2:0]});
    assign w_acc_sel    = REG_W'({w_cls, 3'b000});
    assign w_op_reg_sel = REG_W'({w_stk_cls, w_p[2:0]});
    assign w_rm_type    = (in_modrm[7:6] == 2'b11) ? T_REG : T_MEM;

    always_comb begin
        w_dec          = '0;
        w_dec.alu_op   = ALU_NOP;
        w_dec.uop_last = 1'b1;
        w_is_xchg      = 1'b0;
        if (w_p <= 8'h3D && w_p[2:0] <= 3'd3) begin
            w_dec.size    = w_size;
            w_dec.alu_op  = ALU_W'(w_p[5:3]);
            w_dec.flag_wr = 1'b1;
            if (w_d) begin
                w_dec.op0_type = T_REG;     w_dec.op0_reg = w_reg_sel;
                w_dec.op1_type = w_rm_type; w_dec.op1_reg = w_rm_sel;
            end else begin
                w_dec.op0_type = w_rm_type; w_dec.op0_reg = w_rm_sel;
                w_dec.op1_type = T_REG;     w_dec.op1_reg = w_reg_sel;
            end
        end else if (w_p <= 8'h3D && w_p[2:1] == 2'b10) begin
            w_dec.size     = w_size;
            w_dec.alu_op   = ALU_W'(w_p[5:3]);
            w_dec.flag_wr  = 1'b1;
            w_dec.op0_type = T_REG;
            w_dec.op0_reg  = w_acc_sel;
            w_dec.op1_type = T_IMM;
        end else if (w_p == 8'h80 || w_p == 8'h81 || w_p == 8'h83) begin
            w_dec.size     = w_size;
            w_dec.alu_op   = ALU_W'(in_modrm[5:3]);
            w_dec.flag_wr  = 1'b1;
            w_dec.op0_type = w_rm_type;
            w_dec.op0_reg  = w_rm_sel;
            w_dec.op1_type = T_IMM;
        end else if (w_p[7:2] == 6'b100010) begin
            w_dec.size   = w_size;
            w_dec.alu_op = ALU_MOV;
            if (w_d) begin
                w_dec.op0_type = T_REG;     w_dec.op0_reg = w_reg_sel;
                w_dec.op1_type = w_rm_type; w_dec.op1_reg = w_rm_sel;
            end else begin
                w_dec.op0_type = w_rm_type; w_dec.op0_reg = w_rm_sel;
                w_dec.op1_type = T_REG;     w_dec.op1_reg = w_reg_sel;
            end
        end else if (w_p[7:1] == 7'b1000011) begin
            w_is_xchg      = 1'b1;
            w_dec.size     = w_size;
            w_dec.alu_op   = ALU_XCHG;
            w_dec.op0_type = T_REG;     w_dec.op0_reg = w_reg_sel;
            w_dec.op1_type = w_rm_type; w_dec.op1_reg = w_rm_sel;
            w_dec.uop_last = (EXPAND_XCHG == 0) ? 1'b1 : 1'b0;
        end else if (w_p[7:4] == 4'h5) begin
            // PUSH/POP are plain moves to/from the stack slot.
            w_dec.size   = w_stk_size;
            w_dec.alu_op = ALU_MOV;
            if (!w_p[3]) begin
                w_dec.stack_op = 2'b01;
                w_dec.op0_type = T_STK;
                w_dec.op1_type = T_REG; w_dec.op1_reg = w_op_reg_sel;
            end else begin
                w_dec.stack_op = 2'b10;
                w_dec.op0_type = T_REG; w_dec.op0_reg = w_op_reg_sel;
                w_dec.op1_type = T_STK;
            end
        end else if (w_p == 8'hFC) begin
            w_dec.cleard = 1'b1;
        end else if (w_p == 8'hFD) begin
            w_dec.setd = 1'b1;
        end else begin
            w_dec.illegal = 1'b1;
        end
    end

    always_comb begin
        w_dec_u1          = w_dec;
        w_dec_u1.op0_type = w_dec.op1_type;
        w_dec_u1.op0_reg  = w_dec.op1_reg;
        w_dec_u1.op1_type = w_dec.op0_type;
        w_dec_u1.op1_reg  = w_dec.op0_reg;
        w_dec_u1.uop_idx  = UOP_IDX_W'(1);
        w_dec_u1.uop_last = 1'b1;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_valid_nxt = r_out_vld;
        w_in_rdy    = 1'b0;
        w_ld_dec    = 1'b0;
        w_ld_u1     = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_in_rdy = !flush && (!r_out_vld || out_ready);
                if (in_valid && w_in_rdy) begin
                    w_ld_dec    = 1'b1;
                    w_valid_nxt = 1'b1;
                    if (w_is_xchg && EXPAND_XCHG != 0) w_state_nxt = S_EXP1;
                end else if (out_ready) begin
                    w_valid_nxt = 1'b0;
                end
            end
            S_EXP1: begin
                if (out_ready) begin
                    w_ld_u1     = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        // Flush wins over everything, including the pending second uop.
        if (flush) begin
            w_state_nxt = S_IDLE;
            w_valid_nxt = 1'b0;
            w_ld_dec    = 1'b0;
            w_ld_u1     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_vld       <= 1'b0;
            r_uop           <= '0;
            r_uop.alu_op    <= ALU_NOP;
            r_uop.uop_last  <= 1'b1;
            r_uop1          <= '0;
        end else begin
            r_out_vld <= w_valid_nxt;
            if (w_ld_dec) begin
                r_uop  <= w_dec;
                r_uop1 <= w_dec_u1;
            end else if (w_ld_u1) begin
                r_uop <= r_uop1;
            end
        end
    end

    assign in_ready     = w_in_rdy;
    assign out_valid    = r_out_vld;
    assign out_setd     = r_uop.setd;
    assign out_cleard   = r_uop.cleard;
    assign out_size     = r_uop.size;
    assign out_op0_type = r_uop.op0_type;
    assign out_op1_type = r_uop.op1_type;
    assign out_op0_reg  = r_uop.op0_reg;
    assign out_op1_reg  = r_uop.op1_reg;
    assign out_alu_op   = r_uop.alu_op;
    assign out_flag_wr  = r_uop.flag_wr;
    assign out_stack_op = r_uop.stack_op;
    assign out_uop_idx  = r_uop.uop_idx;
    assign out_uop_last = r_uop.uop_last;
    assign out_illegal  = r_uop.illegal;

endmodule

// File: tb/tb_decode_ctrl_seq.sv
// Directed bench for decode_ctrl_seq: decode vector table plus stall, flush and reset sequences.
module tb_decode_ctrl_seq;

    logic        clk = 1'b0;
    logic        reset, flush, in_valid, in_ready, in_sizeov;
    logic [15:0] in_opcode;
    logic [7:0]  in_modrm;
    logic        out_valid, out_ready, out_setd, out_cleard;
    logic [2:0]  out_size, out_op0_type, out_op1_type;
    logic [4:0]  out_op0_reg, out_op1_reg;
    logic [3:0]  out_alu_op;
    logic        out_flag_wr;
    logic [1:0]  out_stack_op;
    logic [0:0]  out_uop_idx;
    logic        out_uop_last, out_illegal;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    decode_ctrl_seq dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_sizeov(in_sizeov),
        .in_opcode(in_opcode), .in_modrm(in_modrm),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_setd(out_setd), .out_cleard(out_cleard), .out_size(out_size),
        .out_op0_type(out_op0_type), .out_op1_type(out_op1_type),
        .out_op0_reg(out_op0_reg), .out_op1_reg(out_op1_reg),
        .out_alu_op(out_alu_op), .out_flag_wr(out_flag_wr),
        .out_stack_op(out_stack_op), .out_uop_idx(out_uop_idx),
        .out_uop_last(out_uop_last), .out_illegal(out_illegal)
    );

    typedef struct packed {
        logic        sz;
        logic [15:0] opc;
        logic [7:0]  mrm;
        logic [2:0]  size;
        logic [2:0]  t0;
        logic [2:0]  t1;
        logic [4:0]  r0;
        logic [4:0]  r1;
        logic [3:0]  alu;
        logic        fw;
        logic [1:0]  stk;
        logic        setd;
        logic        cleard;
        logic        ill;
        logic        lst;
    } vec_t;

    function automatic vec_t mk(input logic sz, input logic [15:0] opc, input logic [7:0] mrm,
                                input logic [2:0] size, input logic [2:0] t0, input logic [2:0] t1,
                                input logic [4:0] r0, input logic [4:0] r1, input logic [3:0] alu,
                                input logic fw, input logic [1:0] stk, input logic setd,
                                input logic cleard, input logic ill, input logic lst);
        vec_t v;
        v.sz = sz; v.opc = opc; v.mrm = mrm; v.size = size; v.t0 = t0; v.t1 = t1;
        v.r0 = r0; v.r1 = r1; v.alu = alu; v.fw = fw; v.stk = stk;
        v.setd = setd; v.cleard = cleard; v.ill = ill; v.lst = lst;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", nm, act, exp);
        end
    endtask

    task automatic check_uop(input string tag, input vec_t e, input logic idx, input logic vld);
        chk({tag, ".valid"},   32'(out_valid),    32'(vld));
        chk({tag, ".size"},    32'(out_size),     32'(e.size));
        chk({tag, ".op0_type"},32'(out_op0_type), 32'(e.t0));
        chk({tag, ".op1_type"},32'(out_op1_type), 32'(e.t1));
        chk({tag, ".op0_reg"}, 32'(out_op0_reg),  32'(e.r0));
        chk({tag, ".op1_reg"}, 32'(out_op1_reg),  32'(e.r1));
        chk({tag, ".alu_op"},  32'(out_alu_op),   32'(e.alu));
        chk({tag, ".flag_wr"}, 32'(out_flag_wr),  32'(e.fw));
        chk({tag, ".stack_op"},32'(out_stack_op), 32'(e.stk));
        chk({tag, ".setd"},    32'(out_setd),     32'(e.setd));
        chk({tag, ".cleard"},  32'(out_cleard),   32'(e.cleard));
        chk({tag, ".illegal"}, 32'(out_illegal),  32'(e.ill));
        chk({tag, ".last"},    32'(out_uop_last), 32'(e.lst));
        chk({tag, ".idx"},     32'(out_uop_idx),  32'(idx));
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic sz, input logic [15:0] opc, input logic [7:0] mrm);
        in_valid  = 1'b1;
        in_sizeov = sz;
        in_opcode = opc;
        in_modrm  = mrm;
    endtask

    vec_t vecs[14];
    vec_t v_rst, v_x0, v_x1, v_add;

    initial begin
        //                   sz    opc       mrm    size  t0 t1 r0     r1     alu fw stk sd cd il last
        vecs[0]  = mk(1'b0, 16'h0001, 8'hC8, 3'b100, 1, 1, 5'h10, 5'h11, 0,  1, 0, 0, 0, 0, 1);
        vecs[1]  = mk(1'b1, 16'h0089, 8'h45, 3'b010, 2, 1, 5'h0D, 5'h08, 8,  0, 0, 0, 0, 0, 1);
        vecs[2]  = mk(1'b0, 16'h0002, 8'hD3, 3'b001, 1, 1, 5'h02, 5'h03, 0,  1, 0, 0, 0, 0, 1);
        vecs[3]  = mk(1'b1, 16'h002B, 8'h06, 3'b010, 1, 2, 5'h08, 5'h0E, 5,  1, 0, 0, 0, 0, 1);
        vecs[4]  = mk(1'b0, 16'h003D, 8'h00, 3'b100, 1, 3, 5'h10, 5'h00, 7,  1, 0, 0, 0, 0, 1);
        vecs[5]  = mk(1'b0, 16'h0083, 8'hE9, 3'b100, 1, 3, 5'h11, 5'h00, 5,  1, 0, 0, 0, 0, 1);
        vecs[6]  = mk(1'b0, 16'h0053, 8'h00, 3'b100, 4, 1, 5'h00, 5'h13, 8,  0, 1, 0, 0, 0, 1);
        vecs[7]  = mk(1'b1, 16'h005A, 8'h00, 3'b010, 1, 4, 5'h0A, 5'h00, 8,  0, 2, 0, 0, 0, 1);
        vecs[8]  = mk(1'b0, 16'h010F, 8'h00, 3'b000, 0, 0, 5'h00, 5'h00, 15, 0, 0, 0, 0, 1, 1);
        vecs[9]  = mk(1'b0, 16'h00FD, 8'h00, 3'b000, 0, 0, 5'h00, 5'h00, 15, 0, 0, 1, 0, 0, 1);
        vecs[10] = mk(1'b0, 16'h00FC, 8'h00, 3'b000, 0, 0, 5'h00, 5'h00, 15, 0, 0, 0, 1, 0, 1);
        vecs[11] = mk(1'b0, 16'h00F4, 8'h00, 3'b000, 0, 0, 5'h00, 5'h00, 15, 0, 0, 0, 0, 1, 1);
        vecs[12] = mk(1'b0, 16'h0088, 8'hC1, 3'b001, 1, 1, 5'h01, 5'h00, 8,  0, 0, 0, 0, 0, 1);
        vecs[13] = mk(1'b0, 16'h0082, 8'h00, 3'b000, 0, 0, 5'h00, 5'h00, 15, 0, 0, 0, 0, 1, 1);
        v_rst = mk(1'b0, 16'h0, 8'h0, 3'b000, 0, 0, 5'h00, 5'h00, 15, 0, 0, 0, 0, 0, 1);
        v_x0  = mk(1'b0, 16'h0087, 8'hD9, 3'b100, 1, 1, 5'h13, 5'h11, 9, 0, 0, 0, 0, 0, 0);
        v_x1  = mk(1'b0, 16'h0087, 8'hD9, 3'b100, 1, 1, 5'h11, 5'h13, 9, 0, 0, 0, 0, 0, 1);
        v_add = mk(1'b0, 16'h0000, 8'hC8, 3'b001, 1, 1, 5'h00, 5'h01, 0, 1, 0, 0, 0, 0, 1);

        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_sizeov = 1'b0;
        in_opcode = 16'h0; in_modrm = 8'h0; out_ready = 1'b1;
        repeat (3) tick;
        reset = 1'b0;
        #1;
        check_uop("reset", v_rst, 1'b0, 1'b0);
        chk("reset.in_ready", 32'(in_ready), 32'd1);

        // Back-to-back table: one new instruction every cycle, out_ready held high.
        for (int i = 0; i < 14; i++) begin
            drive(vecs[i].sz, vecs[i].opc, vecs[i].mrm);
            #1;
            chk($sformatf("vec%0d.in_ready", i), 32'(in_ready), 32'd1);
            tick;
            check_uop($sformatf("vec%0d", i), vecs[i], 1'b0, 1'b1);
        end
        in_valid = 1'b0;
        tick;
        chk("drain.valid", 32'(out_valid), 32'd0);

        // XCHG expansion under downstream stall; in_* bus scrambled after accept.
        out_ready = 1'b0;
        drive(1'b0, 16'h0087, 8'hD9);
        #1;
        chk("xchg.accept_rdy", 32'(in_ready), 32'd1);
        tick;
        in_valid = 1'b0; in_opcode = 16'h0001; in_modrm = 8'h00; in_sizeov = 1'b1;
        #1;
        check_uop("xchg.u0", v_x0, 1'b0, 1'b1);
        for (int c = 0; c < 3; c++) begin
            tick;
            check_uop($sformatf("xchg.hold%0d", c), v_x0, 1'b0, 1'b1);
            chk($sformatf("xchg.hold%0d.in_ready", c), 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        #1;
        chk("xchg.exp1_rdy", 32'(in_ready), 32'd0);
        tick;
        check_uop("xchg.u1", v_x1, 1'b1, 1'b1);
        chk("xchg.u1.in_ready", 32'(in_ready), 32'd1);
        tick;
        chk("xchg.done.valid", 32'(out_valid), 32'd0);

        // Flush while uop0 is pending in EXP1, with a new ADD waiting.
        out_ready = 1'b0;
        drive(1'b0, 16'h0087, 8'hD9);
        tick;
        drive(1'b0, 16'h0000, 8'hC8);
        flush = 1'b1;
        #1;
        chk("flush.in_ready", 32'(in_ready), 32'd0);
        tick;
        flush = 1'b0;
        chk("flush.valid", 32'(out_valid), 32'd0);
        out_ready = 1'b1;
        #1;
        chk("flush.idle_rdy", 32'(in_ready), 32'd1);
        tick;
        in_valid = 1'b0;
        check_uop("flush.add", v_add, 1'b0, 1'b1);
        tick;
        chk("flush.no_u1", 32'(out_valid), 32'd0);

        // Reset in the middle of an expansion.
        out_ready = 1'b0;
        drive(1'b0, 16'h0087, 8'hD9);
        tick;
        in_valid = 1'b0;
        reset = 1'b1;
        tick;
        check_uop("midreset", v_rst, 1'b0, 1'b0);
        reset = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("midreset.in_ready", 32'(in_ready), 32'd1);
        tick;
        chk("midreset.valid", 32'(out_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
